addsub_operand_sequencer: RTL and testbench
===========================================

Name: addsub_operand_sequencer

Overview:
- Sequential front end that drives the combinational 4-bit adder/subtractor on the DE10-Lite board.
- Captures operand A, operand B and the add/sub mode from slide switches, one debounced KEY press per step.
- Presents the registered operands to the adder, captures its result and carry, and derives signed overflow.
- Drives one seven-segment digit and status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles of key_n required before a level change is accepted (10 ms at 50 MHz). The bench uses 4.

Ports:
- clk  in  1  system clock (50 MHz MAX10_CLK1_50)
- rst  in  1  asynchronous, active-high reset
- sw  in  4  operand value from slide switches
- sw_mode  in  1  0 = add (A+B), 1 = subtract (A-B); sampled on B confirm
- key_n  in  1  enter push-button, active-low, asynchronous to clk
- adder_a0  out  4  registered operand A to adder
- adder_a1  out  4  registered operand B to adder
- adder_s  out  1  registered mode to adder
- adder_r  in  4  adder result
- adder_cout  in  1  adder carry-out
- hex0_n  out  7  seven-segment digit, active-low, bit6..0 = g..a
- led_carry  out  1  captured adder_cout
- led_ovf  out  1  signed two's-complement overflow of captured operation
- led_phase  out  2  FSM phase: 0 LOAD_A, 1 LOAD_B, 2 EXEC, 3 SHOW
- result_valid  out  1  high while in SHOW

Behaviour:
- Reset (async, rst=1): FSM enters LOAD_A. All of the following clear to 0: adder_a0, adder_a1, adder_s, the captured result, led_carry, led_ovf and result_valid. led_phase=0. The debouncer state is set to released, and hex0_n shows sw.
- Input conditioning: 2-FF synchronizer on key_n, then a debounce counter.
  - The counter restarts whenever the synchronized level differs from the accepted level.
  - The accepted level updates after DEBOUNCE_CYCLES consecutive differing cycles.
  - press = single-cycle pulse on an accepted released->pressed transition.
  - Latency from a clean key_n fall to press = 2 + DEBOUNCE_CYCLES cycles.
- FSM:
  - LOAD_A: hex0_n shows live sw. On press: adder_a0<=sw, go to LOAD_B.
  - LOAD_B: hex0_n shows live sw. On press: adder_a1<=sw, adder_s<=sw_mode, go to EXEC.
  - EXEC: exactly one cycle, press ignored. The adder sees stable registered inputs. Go to SHOW.
  - SHOW, entry edge: result<=adder_r, led_carry<=adder_cout, led_ovf<=(adder_a0[3]==(adder_a1[3]^adder_s)) && (adder_r[3]!=adder_a0[3]).
  - SHOW, while resident: result_valid=1 and hex0_n shows the captured result.
  - SHOW, on press: go to LOAD_A, result_valid<=0. led_carry and led_ovf clear on the same edge. adder_a0, adder_a1 and adder_s hold until overwritten.
- Arithmetic:
  - The adder computes modulo 16.
  - Subtract: cout=1 means no unsigned borrow (A>=B).
  - The sequencer does no arithmetic beyond the overflow expression.
- Seven-segment: standard hex font 0-F, active-low, combinational from the displayed nibble. 0->1000000, 1->1111001, 8->0000000, E->0000110, F->0001110.
- Boundary cases:
  - A held key yields one press only.
  - Bounces shorter than DEBOUNCE_CYCLES yield no press.
  - Release bounces are debounced identically and never generate a press.
  - sw changes after confirm have no effect on stored operands.
  - sw_mode is sampled only at B confirm.
  - A press coincident with the EXEC cycle is dropped.
  - rst asserted in any state returns to LOAD_A immediately (async) and discards in-flight operands.

Test Plan (DEBOUNCE_CYCLES=4, adder model connected):
- 5+3: sw=5 press, sw=3 mode=0 press -> SHOW; hex0_n=0000000 (8), led_carry=0, led_ovf=1, result_valid=1.
- 3-5: sw=3 press, sw=5 mode=1 press -> r=E, hex0_n=0000110, led_carry=0 (borrow), led_ovf=0.
- 7-7 then restart: r=0, led_carry=1, led_ovf=0. Next press -> led_phase=0, result_valid=0, led_carry=0.
- 9+8: r=1, led_carry=1, led_ovf=1 (-7 + -8 overflow). Changing sw in SHOW leaves hex0_n showing 1.
- Bounce: key_n low for 3 cycles then high, repeated -> no phase change. Held low 50 cycles -> exactly one advance.
- Reset mid-op: assert rst in LOAD_B after A=6 -> adder_a0=0, led_phase=0 asynchronously. After release, the sequence 2+2 gives r=4.

Source files
------------

// File: rtl/addsub_operand_sequencer_if.sv
// Operand/result bus between the sequencer and the combinational 4-bit adder/subtractor.
// The sequencer drives registered operands and mode; the adder answers with result and carry.
interface addsub_operand_sequencer_if;
  logic [3:0] adder_a0;
  logic [3:0] adder_a1;
  logic       adder_s;
  logic [3:0] adder_r;
  logic       adder_cout;

  modport master (
    output adder_a0,
    output adder_a1,
    output adder_s,
    input  adder_r,
    input  adder_cout
  );

  modport slave (
    input  adder_a0,
    input  adder_a1,
    input  adder_s,
    output adder_r,
    output adder_cout
  );
endinterface

// File: rtl/addsub_operand_sequencer.sv
// Key-driven front end for the DE10-Lite 4-bit adder/subtractor: loads A, B and mode
// on debounced presses, captures the adder's answer and shows it on one hex digit.
module addsub_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  sw,
  input  logic                        sw_mode,
  input  logic                        key_n,
  addsub_operand_sequencer_if.master  adder,
  output logic [6:0]                  hex0_n,
  output logic                        led_carry,
  output logic                        led_ovf,
  output logic [1:0]                  led_phase,
  output logic                        result_valid
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    SHOW   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          key_meta, key_sync, key_level;
  logic [CW-1:0] deb_cnt;
  logic          press;
  logic [3:0]    result_q;
  logic          ovf_now;
  logic [3:0]    disp_nibble;

  // key_n is active-low, so level 1 means released; press fires only on an accepted fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta  <= 1'b1;
      key_sync  <= 1'b1;
      key_level <= 1'b1;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      press    <= 1'b0;
      if (key_sync != key_level) begin
        if (deb_cnt == CNT_LAST) begin
          key_level <= key_sync;
          deb_cnt   <= '0;
          press     <= ~key_sync;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (press) state_d = LOAD_B;
      LOAD_B:  if (press) state_d = EXEC;
      EXEC:    state_d = SHOW;
      SHOW:    if (press) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Signed overflow: operands effectively share a sign (B inverted for subtract) but the result flips it.
  assign ovf_now = (adder.adder_a0[3] == (adder.adder_a1[3] ^ adder.adder_s)) &&
                   (adder.adder_r[3] != adder.adder_a0[3]);

  // result_valid is a level "valid" with no ready: it is high for the whole SHOW residency
  // and the user's next press acts as the consumer acknowledging it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adder.adder_a0 <= '0;
      adder.adder_a1 <= '0;
      adder.adder_s  <= 1'b0;
      result_q       <= '0;
      led_carry      <= 1'b0;
      led_ovf        <= 1'b0;
      result_valid   <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (press) adder.adder_a0 <= sw;
        LOAD_B: if (press) begin
          adder.adder_a1 <= sw;
          adder.adder_s  <= sw_mode;
        end
        EXEC: begin
          result_q     <= adder.adder_r;
          led_carry    <= adder.adder_cout;
          led_ovf      <= ovf_now;
          result_valid <= 1'b1;
        end
        SHOW: if (press) begin
          led_carry    <= 1'b0;
          led_ovf      <= 1'b0;
          result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign led_phase   = state_q;
  assign disp_nibble = (state_q == SHOW) ? result_q : sw;

  always_comb begin
    hex0_n = 7'b1111111;
    case (disp_nibble)
      4'h0: hex0_n = 7'b1000000;
      4'h1: hex0_n = 7'b1111001;
      4'h2: hex0_n = 7'b0100100;
      4'h3: hex0_n = 7'b0110000;
      4'h4: hex0_n = 7'b0011001;
      4'h5: hex0_n = 7'b0010010;
      4'h6: hex0_n = 7'b0000010;
      4'h7: hex0_n = 7'b1111000;
      4'h8: hex0_n = 7'b0000000;
      4'h9: hex0_n = 7'b0010000;
      4'hA: hex0_n = 7'b0001000;
      4'hB: hex0_n = 7'b0000011;
      4'hC: hex0_n = 7'b1000110;
      4'hD: hex0_n = 7'b0100001;
      4'hE: hex0_n = 7'b0000110;
      4'hF: hex0_n = 7'b0001110;
      default: hex0_n = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// Directed bench for addsub_operand_sequencer with a behavioural 4-bit adder/subtractor attached.
module tb_addsub_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       sw_mode;
  logic       key_n;
  logic [6:0] hex0_n;
  logic       led_carry, led_ovf, result_valid;
  logic [1:0] led_phase;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  addsub_operand_sequencer_if ifc ();

  // Board adder: modulo-16 add, or A + ~B + 1 for subtract (cout=1 means no borrow).
  assign {ifc.adder_cout, ifc.adder_r} = ifc.adder_s ?
      (5'({1'b0, ifc.adder_a0}) + 5'({1'b0, ~ifc.adder_a1}) + 5'd1) :
      (5'({1'b0, ifc.adder_a0}) + 5'({1'b0, ifc.adder_a1}));

  addsub_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .sw_mode      (sw_mode),
    .key_n        (key_n),
    .adder        (ifc),
    .hex0_n       (hex0_n),
    .led_carry    (led_carry),
    .led_ovf      (led_ovf),
    .led_phase    (led_phase),
    .result_valid (result_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       mode;
    logic [3:0] exp_r;
    logic       exp_c;
    logic       exp_v;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: clean press held for 'hold' cycles, then a quiet release
  task automatic press_key(input int hold);
    key_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_vector(input vec_t v);
    sw = v.a;
    sw_mode = ~v.mode;
    @(negedge clk);
    check("hex_live_a", 8'(hex0_n), 8'(font(v.a)));
    press_key(10);
    check("phase_load_b", 8'(led_phase), 8'd1);
    check("a0_loaded", 8'(ifc.adder_a0), 8'(v.a));
    sw = v.b;
    sw_mode = v.mode;
    exp_q.push_back(v.exp_r);
    press_key(10);
    // operand switches move after confirm: stored values must not follow
    sw = v.a ^ 4'hF;
    sw_mode = ~v.mode;
    @(negedge clk);
    check("a0_held", 8'(ifc.adder_a0), 8'(v.a));
    check("a1_held", 8'(ifc.adder_a1), 8'(v.b));
    check("s_held", 8'(ifc.adder_s), 8'(v.mode));
    check("phase_show", 8'(led_phase), 8'd3);
    check("result_valid", 8'(result_valid), 8'd1);
    check("led_carry", 8'(led_carry), 8'(v.exp_c));
    check("led_ovf", 8'(led_ovf), 8'(v.exp_v));
    if (exp_q.size() == 0) check("sb_queue", 8'd0, 8'd1);
    else check("hex_result", 8'(hex0_n), 8'(font(exp_q.pop_front())));
    press_key(10);
    check("phase_restart", 8'(led_phase), 8'd0);
    check("valid_clear", 8'(result_valid), 8'd0);
    check("carry_clear", 8'(led_carry), 8'd0);
    check("ovf_clear", 8'(led_ovf), 8'd0);
  endtask

  initial begin
    //             a      b      mode  r      c     v
    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[1] = '{4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0};
    vecs[2] = '{4'h7, 4'h7, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[3] = '{4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1};
    vecs[4] = '{4'h6, 4'hE, 1'b1, 4'h8, 1'b0, 1'b1};
    vecs[5] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};

    rst = 1'b1;
    sw = 4'h5;
    sw_mode = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_phase", 8'(led_phase), 8'd0);
    check("rst_a0", 8'(ifc.adder_a0), 8'd0);
    check("rst_a1", 8'(ifc.adder_a1), 8'd0);
    check("rst_s", 8'(ifc.adder_s), 8'd0);
    check("rst_carry", 8'(led_carry), 8'd0);
    check("rst_ovf", 8'(led_ovf), 8'd0);
    check("rst_valid", 8'(result_valid), 8'd0);
    check("rst_hex", 8'(hex0_n), 8'(font(4'h5)));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // short bounces never reach the debounce threshold
    for (int i = 0; i < 6; i++) begin
      key_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      key_n = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("bounce_no_press", 8'(led_phase), 8'd0);

    // long hold with a bouncy release: exactly one advance
    sw = 4'h6;
    key_n = 1'b0;
    repeat (50) @(negedge clk);
    check("held_one_press", 8'(led_phase), 8'd1);
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      key_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    check("release_no_press", 8'(led_phase), 8'd1);
    check("held_a0", 8'(ifc.adder_a0), 8'h6);

    // asynchronous reset mid-operation, between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a0", 8'(ifc.adder_a0), 8'd0);
    check("async_rst_a1", 8'(ifc.adder_a1), 8'd0);
    check("async_rst_phase", 8'(led_phase), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_vector('{4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0});

    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
